// File: rtl/prime_check.sv
// prime_check -- responder-side primality tester for the go/ready/error handshake.
//
// A sequencer presents a candidate on n and pulses go while ready=1. The block
// resolves trivial candidates directly and otherwise runs trial division by odd
// divisors 3, 5, 7, ... using a one-bit-per-cycle restoring divider. The search
// stops as soon as d*d exceeds the candidate. The square is maintained
// incrementally, so no multiplier is needed.
//
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset; aborts any test in progress
//   go        start request, honoured only while ready=1 and error=0
//   n         W-bit candidate, sampled with an accepted go
//   ready     1 = idle, result valid, new go accepted
//   error     sticky: set by a go while busy, cleared only by rst
//   is_prime  result of the last completed test
module prime_check #(
   parameter int WIDTH_LOG = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        go,
   input  logic [(1<<WIDTH_LOG)-1:0]   n,
   output logic                        ready,
   output logic                        error,
   output logic                        is_prime
);

   localparam int W  = 1 << WIDTH_LOG;
   localparam int SW = 2 * W;
   localparam int RW = W + 1;
   localparam int CW = WIDTH_LOG + 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      CHECK = 2'd2,
      DIV   = 2'd3
   } state_t;

   state_t           state, state_next;
   logic             error_next;
   logic             prime_next;

   logic [W-1:0]     nr,  nr_next;
   logic [W-1:0]     d,   d_next;
   logic [SW-1:0]    sq,  sq_next;
   logic [RW-1:0]    rem, rem_next;
   logic [W-1:0]     quo, quo_next;
   logic [CW-1:0]    cnt, cnt_next;

   // Restoring divider step: shift the next candidate bit into the remainder,
   // then subtract the divisor if it fits. rem always stays below d, so the
   // shift into W+1 bits never loses information.
   logic [RW-1:0]    t;
   logic [RW-1:0]    rem_step;

   always_comb begin
      t        = (rem << 1) | RW'(quo[W-1]);
      rem_step = (t >= RW'(d)) ? (t - RW'(d)) : t;
   end

   assign ready = (state == IDLE);

   always_comb begin
      state_next = state;
      error_next = error;
      prime_next = is_prime;
      nr_next    = nr;
      d_next     = d;
      sq_next    = sq;
      rem_next   = rem;
      quo_next   = quo;
      cnt_next   = cnt;

      // A go arriving while busy is a protocol violation; the running test
      // is unaffected.
      if (go && (state != IDLE)) begin
         error_next = 1'b1;
      end

      case (state)
         IDLE: begin
            if (go && !error) begin
               nr_next    = n;
               prime_next = 1'b0;
               state_next = START;
            end
         end

         START: begin
            if (nr < W'(2)) begin
               prime_next = 1'b0;
               state_next = IDLE;
            end else if (nr == W'(2)) begin
               prime_next = 1'b1;
               state_next = IDLE;
            end else if (!nr[0]) begin
               prime_next = 1'b0;
               state_next = IDLE;
            end else begin
               d_next     = W'(3);
               sq_next    = SW'(9);
               state_next = CHECK;
            end
         end

         CHECK: begin
            if (sq > SW'(nr)) begin
               prime_next = 1'b1;
               state_next = IDLE;
            end else begin
               rem_next   = '0;
               quo_next   = nr;
               cnt_next   = CW'(W);
               state_next = DIV;
            end
         end

         DIV: begin
            quo_next = quo << 1;
            rem_next = rem_step;
            cnt_next = cnt - CW'(1);
            // Last step: the final remainder decides in this same cycle.
            if (cnt == CW'(1)) begin
               if (rem_step == '0) begin
                  prime_next = 1'b0;
                  state_next = IDLE;
               end else begin
                  // (d+2)^2 = d^2 + 4d + 4
                  sq_next    = sq + (SW'(d) << 2) + SW'(4);
                  d_next     = d + W'(2);
                  state_next = CHECK;
               end
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         error    <= 1'b0;
         is_prime <= 1'b0;
      end else begin
         state    <= state_next;
         error    <= error_next;
         is_prime <= prime_next;
      end
   end

   // Datapath registers carry no reset; they are always reloaded before use.
   always_ff @(posedge clk) begin
      nr  <= nr_next;
      d   <= d_next;
      sq  <= sq_next;
      rem <= rem_next;
      quo <= quo_next;
      cnt <= cnt_next;
   end

endmodule

// File: tb/tb_prime_check.sv
// tb_prime_check -- table-driven bench for prime_check (W=16) plus hand-written
// sequences for reset, protocol error and a back-to-back sweep.
module tb_prime_check;

   localparam int W     = 16;
   localparam int BOUND = 5000;

   logic          clk;
   logic          rst;
   logic          go;
   logic [W-1:0]  n;
   logic          ready;
   logic          error;
   logic          is_prime;

   int n_checks;
   int n_fail;

   prime_check #(.WIDTH_LOG(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .go       (go),
      .n        (n),
      .ready    (ready),
      .error    (error),
      .is_prime (is_prime)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int unsigned cand;
      int          exp_prime;
      int          exp_lat;
   } vec_t;

   vec_t vecs[12];
   bit   composite[1024];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Called at a negedge. Drives go for one cycle, then counts cycles with
   // ready=0 (sampled at negedges) until ready returns, bounded.
   task automatic run_test(input logic [W-1:0] val, output int lat,
                           output int prime_out, output int err_seen);
      go  = 1'b1;
      n   = val;
      @(negedge clk);
      go  = 1'b0;
      n   = '0;
      lat = 0;
      err_seen = 0;
      while (!ready && lat < BOUND) begin
         if (error) err_seen = 1;
         lat++;
         @(negedge clk);
      end
      if (error) err_seen = 1;
      prime_out = int'(is_prime);
   endtask

   initial begin
      int lat, pr, es, wait_cnt, sweep_err;
      n_checks = 0;
      n_fail   = 0;
      go  = 1'b0;
      n   = '0;
      rst = 1'b1;

      // software sieve over 0..1023
      for (int i = 0; i < 1024; i++) composite[i] = (i < 2);
      for (int i = 2; i * i < 1024; i++)
         if (!composite[i])
            for (int j = i * i; j < 1024; j += i) composite[j] = 1'b1;

      vecs[0]  = '{0,     0, 1};
      vecs[1]  = '{1,     0, 1};
      vecs[2]  = '{2,     1, 1};
      vecs[3]  = '{4,     0, 1};
      vecs[4]  = '{3,     1, 2};
      vecs[5]  = '{9,     0, 18};
      vecs[6]  = '{65521, 1, 2161};
      vecs[7]  = '{65535, 0, 18};
      vecs[8]  = '{5,     1, 2};
      vecs[9]  = '{15,    0, 18};
      vecs[10] = '{25,    0, 35};
      vecs[11] = '{49,    1, 0};
      // 49 = 7*7: d=3 (17), d=5 (17), d=7 divides -> composite, L=1+17+17+1+16
      vecs[11].exp_prime = 0;
      vecs[11].exp_lat   = 52;

      repeat (2) @(negedge clk);
      rst = 1'b0;

      // reset state
      check("reset_ready",    int'(ready),    1);
      check("reset_error",    int'(error),    0);
      check("reset_is_prime", int'(is_prime), 0);

      // directed table
      foreach (vecs[i]) begin
         run_test(W'(vecs[i].cand), lat, pr, es);
         check($sformatf("prime_n%0d", vecs[i].cand), pr, vecs[i].exp_prime);
         check($sformatf("lat_n%0d", vecs[i].cand), lat, vecs[i].exp_lat);
         check($sformatf("err_n%0d", vecs[i].cand), es, 0);
      end

      // reset 100 cycles into the n=65521 test
      go = 1'b1;
      n  = W'(65521);
      @(negedge clk);
      go = 1'b0;
      repeat (99) @(negedge clk);
      check("midrst_busy", int'(ready), 0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_ready",    int'(ready),    1);
      check("midrst_error",    int'(error),    0);
      check("midrst_is_prime", int'(is_prime), 0);
      run_test(W'(7), lat, pr, es);
      check("after_rst_prime_n7", pr, 1);
      check("after_rst_lat_n7", lat, 2);

      // protocol error: second go 5 cycles into a long test
      go = 1'b1;
      n  = W'(65521);
      @(negedge clk);
      go = 1'b0;
      check("perr_error_before", int'(error), 0);
      repeat (4) @(negedge clk);
      go = 1'b1;
      n  = W'(2);
      @(negedge clk);
      go = 1'b0;
      check("perr_error_set", int'(error), 1);
      wait_cnt = 0;
      while (!ready && wait_cnt < BOUND) begin
         wait_cnt++;
         @(negedge clk);
      end
      check("perr_completed", int'(ready), 1);
      check("perr_is_prime", int'(is_prime), 1);
      check("perr_error_sticky", int'(error), 1);
      go = 1'b1;
      n  = W'(4);
      @(negedge clk);
      go = 1'b0;
      check("perr_go_ignored_ready", int'(ready), 1);
      check("perr_go_ignored_prime", int'(is_prime), 1);
      @(negedge clk);
      check("perr_go_ignored_ready2", int'(ready), 1);

      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_clears_error", int'(error), 0);

      // back-to-back sweep against the sieve
      sweep_err = 0;
      for (int v = 0; v < 1024; v++) begin
         run_test(W'(v), lat, pr, es);
         if (es != 0) sweep_err = 1;
         check($sformatf("sweep_n%0d", v), pr, composite[v] ? 0 : 1);
      end
      check("sweep_error_never", sweep_err, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
